// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and FSM encoding for the register-file write-port sequencer.
package regfile_pkg;
   localparam int DEF_N = 4;
   localparam int DEF_S = 32;
   localparam int NREG  = 1 << DEF_N;
   typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/regfile_wr_arb_pick.sv
// rr_arb_pick: combinational round-robin picker (rotate by ptr, priority-encode, rotate back).
module rr_arb_pick #(
   parameter int M  = 4,
   parameter int PW = $clog2(M)
) (
   input  logic [M-1:0]  req,
   input  logic [PW-1:0] ptr,
   input  logic          en,
   output logic [M-1:0]  gnt,
   output logic [PW-1:0] idx
);
   logic [M-1:0]  rot;
   logic [PW-1:0] off;
   // Sum modulo M without relying on power-of-two wrap.
   function automatic logic [PW-1:0] add_wrap(logic [PW-1:0] a, logic [PW-1:0] b);
      logic [PW:0] s;
      s = {1'b0, a} + {1'b0, b};
      return PW'(s >= (PW+1)'(M) ? s - (PW+1)'(M) : s);
   endfunction
   always_comb begin
      rot = '0;
      off = '0;
      for (int j = 0; j < M; j++) rot[j] = req[add_wrap(ptr, PW'(j))];
      for (int j = M - 1; j >= 0; j--) if (rot[j]) off = PW'(j);
      idx = add_wrap(ptr, off);
      gnt = '0;
      gnt[idx] = en & |req;
   end
endmodule

// File: rtl/regfile_wr_arb.sv
// regfile_wr_arb: clears the register file after reset, then round-robin shares its write port.
// Outputs wr/rD/D are registered and drive the register file directly.
module regfile_wr_arb
   import regfile_pkg::*;
#(
   parameter int M = 4,
   parameter int N = DEF_N,
   parameter int S = DEF_S
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         hold,
   input  logic [M-1:0] req,
   input  logic [M*N-1:0] req_rd,
   input  logic [M*S-1:0] req_d,
   output logic [M-1:0] gnt,
   output logic         wr,
   output logic [N-1:0] rD,
   output logic [S-1:0] D,
   output logic         init_done
);
   localparam int PW = $clog2(M);
   state_t        state_q, state_d;
   logic [N-1:0]  cnt_q, cnt_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic          wr_q, wr_d, done_q, done_d;
   logic [N-1:0]  rd_q, rd_d;
   logic [S-1:0]  d_q, d_d;
   logic [PW-1:0] idx;
   logic [N-1:0]  rd_a [M];
   logic [S-1:0]  d_a [M];
   for (genvar i = 0; i < M; i++) begin : g_slice
      assign rd_a[i] = req_rd[i*N +: N];
      assign d_a[i]  = req_d[i*S +: S];
   end
   rr_arb_pick #(.M(M), .PW(PW)) u_pick (
      .req (req),
      .ptr (ptr_q),
      .en  (state_q == RUN && !hold),
      .gnt (gnt),
      .idx (idx)
   );
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      wr_d    = 1'b0;
      rd_d    = rd_q;
      d_d     = d_q;
      done_d  = done_q;
      if (state_q == INIT) begin
         wr_d  = 1'b1;
         rd_d  = cnt_q;
         d_d   = '0;
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == {N{1'b1}}) begin
            state_d = RUN;
            done_d  = 1'b1;
         end
      end else if (|gnt) begin
         wr_d  = 1'b1;
         rd_d  = rd_a[idx];
         d_d   = d_a[idx];
         ptr_d = (idx == PW'(M - 1)) ? '0 : idx + 1'b1;
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= INIT;
         cnt_q   <= '0;
         ptr_q   <= '0;
         wr_q    <= 1'b0;
         rd_q    <= '0;
         d_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         d_q     <= d_d;
         done_q  <= done_d;
      end
   end
   assign wr        = wr_q;
   assign rD        = rd_q;
   assign D         = d_q;
   assign init_done = done_q;
endmodule

// File: tb/tb_regfile_wr_arb.sv
// tb_regfile_wr_arb: random and directed stimulus; model predicts grants and pushes expected
// writes into a queue that an independent monitor drains whenever wr is presented.
module tb_regfile_wr_arb;
   localparam int M = 4, N = 4, S = 32, NREG = 1 << N;
   logic clk = 1'b0, reset = 1'b0, hold = 1'b0;
   logic [M-1:0]   req = '0;
   logic [M*N-1:0] req_rd = '0;
   logic [M*S-1:0] req_d = '0;
   logic [M-1:0]   gnt;
   logic           wr, init_done;
   logic [N-1:0]   rD;
   logic [S-1:0]   D;
   int checks = 0, errors = 0;
   typedef struct {logic [N-1:0] a; logic [S-1:0] d; logic sweep;} wr_t;
   wr_t q[$];
   int m_ptr = 0, m_cnt = 0, sweep_seen = 0;
   bit m_run = 1'b0;
   logic [M-1:0] m_gnt = '0;
   logic [S-1:0] m_mem [NREG];
   logic [S-1:0] rf [NREG];

   always #5 clk = ~clk;

   regfile_wr_arb #(.M(M), .N(N), .S(S)) dut (
      .clk(clk), .reset(reset), .hold(hold), .req(req), .req_rd(req_rd), .req_d(req_d),
      .gnt(gnt), .wr(wr), .rD(rD), .D(D), .init_done(init_done)
   );

   always @(posedge clk) if (wr) rf[rD] <= D;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int pick(logic [M-1:0] r, int p);
      for (int k = 0; k < M; k++) if (r[(p + k) % M]) return (p + k) % M;
      return -1;
   endfunction

   // Reference model: decides what the arbiter should do this cycle.
   always @(negedge clk) if (reset) begin
      logic [M-1:0] eg;
      int g;
      eg = '0;
      if (!m_run) begin
         q.push_back('{N'(m_cnt), S'(0), 1'b1});
         m_mem[m_cnt] = '0;
         if (m_cnt == NREG - 1) m_run = 1'b1;
         m_cnt++;
      end else begin
         g = hold ? -1 : pick(req, m_ptr);
         if (g >= 0) begin
            eg[g] = 1'b1;
            q.push_back('{req_rd[g*N +: N], req_d[g*S +: S], 1'b0});
            m_mem[req_rd[g*N +: N]] = req_d[g*S +: S];
            m_ptr = (g + 1) % M;
         end
      end
      chk("gnt", gnt, eg);
      m_gnt = eg;
   end

   // Monitor: every presented write must match the oldest expected one.
   always @(negedge clk) if (reset) begin
      if (wr) begin
         if (q.size() == 0) chk("unexpected_wr", 1, 0);
         else begin
            wr_t e;
            e = q.pop_front();
            chk("rD", rD, e.a);
            chk("D", D, e.d);
            if (e.sweep) sweep_seen++;
         end
      end
      chk("init_done", init_done, sweep_seen == NREG);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_r(int i, logic [N-1:0] a, logic [S-1:0] d);
      req_rd[i*N +: N] = a;
      req_d[i*S +: S]  = d;
   endtask

   task automatic rand_run(int n);
      repeat (n) begin
         for (int i = 0; i < M; i++) begin
            if (!req[i] || m_gnt[i]) begin
               req[i] = 1'($urandom_range(0, 1));
               set_r(i, N'($urandom), $urandom);
            end else if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
         end
         hold = ($urandom_range(0, 7) == 0);
         cyc();
      end
      req = '0;
      hold = 1'b0;
   endtask

   initial begin
      req = '1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_wr", wr, 0);
      chk("rst_rD", rD, 0);
      chk("rst_D", D, 0);
      chk("rst_done", init_done, 0);
      chk("rst_gnt", gnt, 0);
      reset = 1'b1;
      repeat (NREG) cyc();
      req = '0;
      repeat (2) cyc();
      for (int i = 0; i < M; i++) set_r(i, N'(i + 8), 32'h1000 + i);
      req = '1;
      repeat (5) cyc();
      req = '0;
      cyc();
      set_r(2, 4'd5, 32'hDEADBEEF);
      req = 4'b0100;
      repeat (3) cyc();
      req = '0;
      repeat (2) cyc();
      chk("rf5_read", rf[5], 32'hDEADBEEF);
      cyc();
      set_r(0, 4'd1, 32'hA0A0A0A0);
      set_r(2, 4'd2, 32'hC2C2C2C2);
      req = 4'b0101;
      repeat (2) cyc();
      req = '0;
      cyc();
      set_r(0, 4'd3, 32'h11111111);
      set_r(1, 4'd3, 32'h22222222);
      req = 4'b0011;
      hold = 1'b1;
      repeat (2) cyc();
      hold = 1'b0;
      repeat (3) cyc();
      req = '0;
      cyc();
      rand_run(300);
      for (int i = 0; i < M; i++) set_r(i, N'($urandom), $urandom);
      req = '1;
      repeat (2) cyc();
      #1 reset = 1'b0;
      #1;
      chk("mid_rst_wr", wr, 0);
      chk("mid_rst_rD", rD, 0);
      chk("mid_rst_D", D, 0);
      chk("mid_rst_gnt", gnt, 0);
      chk("mid_rst_done", init_done, 0);
      q.delete();
      m_run = 1'b0;
      m_cnt = 0;
      m_ptr = 0;
      sweep_seen = 0;
      cyc();
      reset = 1'b1;
      repeat (NREG) cyc();
      req = '0;
      cyc();
      rand_run(200);
      repeat (3) cyc();
      chk("queue_empty", q.size(), 0);
      for (int a = 0; a < NREG; a++) chk("rf_final", rf[a], m_mem[a]);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
